// File: rtl/num_sdiv.sv
// Signed fixed-point divider: out = sat(trunc((left << OUT_LSB) / right)).
// Restoring division, one quotient bit per cycle, go/done handshake.
module num_sdiv #(
  parameter int LEFT_WIDTH  = 32,
  parameter int RIGHT_WIDTH = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int OUT_LSB     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEFT_WIDTH-1:0]  left,
  input  logic [RIGHT_WIDTH-1:0] right,
  input  logic                   go,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   div_by_zero,
  output logic                   done
);

  localparam int N  = LEFT_WIDTH + OUT_LSB;
  localparam int CW = $clog2(N + 1);
  localparam int QW = ((N > OUT_WIDTH) ? N : OUT_WIDTH) + 1;

  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [QW-1:0]         MAX_MAG  = {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]         MIN_MAG  = MAX_MAG + {{(QW-1){1'b0}}, 1'b1};
  localparam logic [OUT_WIDTH-1:0]  OUT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]  OUT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]  OUT_ONE  = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEFT_WIDTH-1:0] L_ONE    = {{(LEFT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RIGHT_WIDTH-1:0] R_ONE   = {{(RIGHT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [N-1:0]           r_dvd;
  logic [RIGHT_WIDTH-1:0] r_rem;
  logic [RIGHT_WIDTH-1:0] r_dvs;
  logic                   r_neg;
  logic                   r_lneg;
  logic                   r_zero;
  logic [OUT_WIDTH-1:0]   r_out;
  logic                   r_dbz;
  logic                   r_done;

  logic [LEFT_WIDTH-1:0]  w_left_abs;
  logic [RIGHT_WIDTH-1:0] w_right_abs;
  logic [N-1:0]           w_dvd_init;
  logic [RIGHT_WIDTH:0]   w_rem_sh;
  logic                   w_ge;
  logic [RIGHT_WIDTH-1:0] w_rem_next;
  logic [QW-1:0]          w_q_ext;
  logic [OUT_WIDTH-1:0]   w_neg_out;
  logic [OUT_WIDTH-1:0]   w_res;

  // Operand magnitudes; the divisor magnitude is unsigned so abs(min negative) fits.
  always_comb begin
    w_left_abs  = left;
    w_right_abs = right;
    if (left[LEFT_WIDTH-1]) begin
      w_left_abs = ~left + L_ONE;
    end else begin
      w_left_abs = left;
    end
    if (right[RIGHT_WIDTH-1]) begin
      w_right_abs = ~right + R_ONE;
    end else begin
      w_right_abs = right;
    end
    w_dvd_init = N'(w_left_abs) << OUT_LSB;
  end

  // One restoring step: the dividend MSB moves into the remainder, the quotient bit enters at the LSB.
  always_comb begin
    w_rem_sh   = {r_rem, r_dvd[N-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    w_rem_next = w_rem_sh[RIGHT_WIDTH-1:0];
    if (w_ge) begin
      w_rem_next = RIGHT_WIDTH'(w_rem_sh - {1'b0, r_dvs});
    end else begin
      w_rem_next = w_rem_sh[RIGHT_WIDTH-1:0];
    end
  end

  // Sign application and saturation of the unsigned quotient.
  always_comb begin
    w_q_ext   = QW'(r_dvd);
    w_neg_out = ~w_q_ext[OUT_WIDTH-1:0] + OUT_ONE;
    w_res     = OUT_MAX;
    if (r_zero) begin
      if (r_lneg) begin
        w_res = OUT_MIN;
      end else begin
        w_res = OUT_MAX;
      end
    end else if (r_neg) begin
      if (w_q_ext > MIN_MAG) begin
        w_res = OUT_MIN;
      end else begin
        w_res = w_neg_out;
      end
    end else begin
      if (w_q_ext > MAX_MAG) begin
        w_res = OUT_MAX;
      end else begin
        w_res = w_q_ext[OUT_WIDTH-1:0];
      end
    end
  end

  // Control FSM; dropping go during CALC or SIGN abandons the op without touching the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_dvd   <= {N{1'b0}};
      r_rem   <= {RIGHT_WIDTH{1'b0}};
      r_dvs   <= {RIGHT_WIDTH{1'b0}};
      r_neg   <= 1'b0;
      r_lneg  <= 1'b0;
      r_zero  <= 1'b0;
      r_out   <= {OUT_WIDTH{1'b0}};
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_dvd   <= w_dvd_init;
            r_dvs   <= w_right_abs;
            r_rem   <= {RIGHT_WIDTH{1'b0}};
            r_neg   <= left[LEFT_WIDTH-1] ^ right[RIGHT_WIDTH-1];
            r_lneg  <= left[LEFT_WIDTH-1];
            r_zero  <= (right == {RIGHT_WIDTH{1'b0}});
            r_cnt   <= CW'(N);
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (!go) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[N-2:0], w_ge};
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state <= S_SIGN;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_SIGN: begin
          if (!go) begin
            r_state <= S_IDLE;
          end else begin
            r_out   <= w_res;
            r_dbz   <= r_zero;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign div_by_zero = r_dbz;
  assign done        = r_done;

endmodule

// File: tb/tb_num_sdiv.sv
// Bench for num_sdiv: directed table, random ops against an arithmetic model,
// and hand-written abort / async reset / back-to-back sequences.
module tb_num_sdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  l8, r8, o8;
  logic        go8, dz8, dn8;
  logic [7:0]  l12, r12;
  logic [11:0] o12;
  logic        go12, dz12, dn12;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int l;
    int r;
    int q;
    bit dz;
  } vec_t;

  vec_t tbl[14];

  num_sdiv #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_LSB(0)) u8 (
    .clk(clk), .reset(reset), .left(l8), .right(r8), .go(go8),
    .out(o8), .div_by_zero(dz8), .done(dn8)
  );

  num_sdiv #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .OUT_WIDTH(12), .OUT_LSB(4)) u12 (
    .clk(clk), .reset(reset), .left(l12), .right(r12), .go(go12),
    .out(o12), .div_by_zero(dz12), .done(dn12)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division, clamp to the output range.
  function automatic void ref_div(input int l, input int r, input int lsb, input int ow,
                                  output int q, output bit dz);
    longint mx, mn, t;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    if (r == 0) begin
      dz = 1'b1;
      q  = (l < 0) ? int'(mn) : int'(mx);
    end else begin
      dz = 1'b0;
      t  = (longint'(l) * (longint'(1) <<< lsb)) / longint'(r);
      if (t > mx) t = mx;
      if (t < mn) t = mn;
      q = int'(t);
    end
  endfunction

  function automatic int cur_out(input bit w);
    if (w) return int'($signed(o12));
    else   return int'($signed(o8));
  endfunction

  function automatic bit cur_done(input bit w);
    if (w) return dn12;
    else   return dn8;
  endfunction

  function automatic bit cur_dz(input bit w);
    if (w) return dz12;
    else   return dz8;
  endfunction

  task automatic opx(input bit w, input int l, input int r, input int eq, input bit edz,
                     input string nm, input bit keep_go);
    int lat;
    int nlat;
    nlat = w ? 13 : 9;
    @(negedge clk);
    if (w) begin
      l12 = 8'(l); r12 = 8'(r); go12 = 1'b1;
    end else begin
      l8 = 8'(l); r8 = 8'(r); go8 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (w) begin
      l12 = 8'($urandom); r12 = 8'($urandom);
    end else begin
      l8 = 8'($urandom); r8 = 8'($urandom);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cur_done(w) && lat < 40);
    chk({nm, " latency"}, lat, nlat);
    chk({nm, " out"}, cur_out(w), eq);
    chk({nm, " dbz"}, int'(cur_dz(w)), int'(edz));
    if (!keep_go) begin
      if (w) go12 = 1'b0;
      else   go8 = 1'b0;
    end
    @(posedge clk); #1;
    chk({nm, " done pulse"}, int'(cur_done(w)), 0);
  endtask

  task automatic rand_op(input bit w, input int idx);
    int l, r, q;
    bit dz;
    l = int'($urandom_range(0, 255)) - 128;
    r = int'($urandom_range(0, 255)) - 128;
    if ($urandom_range(0, 7) == 0) r = 0;
    ref_div(l, r, w ? 4 : 0, w ? 12 : 8, q, dz);
    opx(w, l, r, q, dz, $sformatf("rand%0d_%0d %0d/%0d", w ? 12 : 8, idx, l, r), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tbl[0]  = '{100, 7, 14, 1'b0};
    tbl[1]  = '{-100, 7, -14, 1'b0};
    tbl[2]  = '{100, -7, -14, 1'b0};
    tbl[3]  = '{-100, -7, 14, 1'b0};
    tbl[4]  = '{7, 0, 127, 1'b1};
    tbl[5]  = '{-7, 0, -128, 1'b1};
    tbl[6]  = '{-128, -1, 127, 1'b0};
    tbl[7]  = '{-128, 1, -128, 1'b0};
    tbl[8]  = '{0, 0, 127, 1'b1};
    tbl[9]  = '{0, -5, 0, 1'b0};
    tbl[10] = '{0, 5, 0, 1'b0};
    tbl[11] = '{127, 1, 127, 1'b0};
    tbl[12] = '{-128, 0, -128, 1'b1};
    tbl[13] = '{-1, 2, 0, 1'b0};

    reset = 1'b1;
    go8 = 1'b0; go12 = 1'b0;
    l8 = 8'd0; r8 = 8'd0; l12 = 8'd0; r12 = 8'd0;
    #2 reset = 1'b0;
    #10;
    chk("reset out8", int'(o8), 0);
    chk("reset done8", int'(dn8), 0);
    chk("reset dbz8", int'(dz8), 0);
    chk("reset out12", int'(o12), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      opx(1'b0, tbl[i].l, tbl[i].r, tbl[i].q, tbl[i].dz, $sformatf("vec%0d", i), 1'b0);
    end

    opx(1'b1, 3, 2, 24, 1'b0, "q4 3/2", 1'b0);
    opx(1'b1, -1, 3, -5, 1'b0, "q4 -1/3", 1'b0);

    for (int i = 0; i < 30; i++) rand_op(1'b0, i);
    for (int i = 0; i < 15; i++) rand_op(1'b1, i);

    // Abort by dropping go part-way through.
    opx(1'b0, 100, 7, 14, 1'b0, "pre-abort 100/7", 1'b0);
    @(negedge clk);
    l8 = 8'd50; r8 = 8'd5; go8 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    go8 = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dn8) seen = 1'b1;
    end
    chk("abort no done", int'(seen), 0);
    chk("abort out held", int'($signed(o8)), 14);
    chk("abort dbz held", int'(dz8), 0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    l8 = 8'd50; r8 = 8'd5; go8 = 1'b1;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async reset out", int'(o8), 0);
    chk("async reset done", int'(dn8), 0);
    go8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    opx(1'b0, 9, 3, 3, 1'b0, "b2b 9/3", 1'b1);
    opx(1'b0, 9, -3, -3, 1'b0, "b2b 9/-3", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
